// File: rtl/axi_lite_mem_responder_if.sv
// axi_lite_mem_responder_if: AXI-Lite bus bundle between a master and the memory responder.
interface axi_lite_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );
    modport slave (
        input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );
endinterface

// File: rtl/axi_lite_mem_responder.sv
// axi_lite_mem_responder: AXI-Lite slave RAM model with byte strobes, fixed read latency
// and SLVERR for addresses outside [BASE_ADDR, BASE_ADDR + DEPTH words).
module axi_lite_mem_responder #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h8000_0000,
    parameter int                    DEPTH        = 1024,
    parameter int                    READ_LATENCY = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    axi_lite_mem_responder_if.slave        bus,
    output logic [31:0]                    rd_count_o,
    output logic [31:0]                    wr_count_o,
    output logic [15:0]                    err_count_o
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
    typedef enum logic {W_COLLECT, W_RESP} w_state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    r_state_e              r_state_q, r_state_d;
    logic [CW-1:0]         r_cnt_q, r_cnt_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [1:0]            r_resp_q, r_resp_d;
    logic                  r_valid_q, r_valid_d;
    logic                  ar_ready_q, ar_ready_d;
    w_state_e              w_state_q, w_state_d;
    logic                  aw_got_q, aw_got_d;
    logic                  w_got_q, w_got_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [NB-1:0]         w_strb_q, w_strb_d;
    logic                  aw_ready_q, aw_ready_d;
    logic                  w_ready_q, w_ready_d;
    logic                  b_valid_q, b_valid_d;
    logic [1:0]            b_resp_q, b_resp_d;
    logic [31:0]           rd_count_q, rd_count_d;
    logic [31:0]           wr_count_q, wr_count_d;
    logic [15:0]           err_count_q, err_count_d;
    logic [16:0]           err_sum;
    logic                  ar_hs, r_hs, aw_hs, w_hs, b_hs, commit;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return a >= BASE_ADDR && ((a - BASE_ADDR) >> OB) < ADDR_WIDTH'(DEPTH);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IW'((a - BASE_ADDR) >> OB);
    endfunction

    assign ar_hs  = bus.ar_valid && ar_ready_q;
    assign r_hs   = r_valid_q && bus.r_ready;
    assign aw_hs  = bus.aw_valid && aw_ready_q;
    assign w_hs   = bus.w_valid && w_ready_q;
    assign b_hs   = b_valid_q && bus.b_ready;
    assign commit = w_state_q == W_COLLECT && aw_got_q && w_got_q;

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        if (r_state_q == R_IDLE && ar_hs) begin
            r_data_d  = in_range(bus.ar_addr) ? mem[word_idx(bus.ar_addr)] : '0;
            r_resp_d  = in_range(bus.ar_addr) ? 2'b00 : 2'b10;
            r_cnt_d   = CW'(READ_LATENCY - 1);
            r_state_d = READ_LATENCY == 1 ? R_RESP : R_WAIT;
        end else if (r_state_q == R_WAIT) begin
            r_cnt_d = r_cnt_q - 1'b1;
            if (r_cnt_q == CW'(1)) r_state_d = R_RESP;
        end else if (r_state_q == R_RESP && r_hs) begin
            r_state_d = R_IDLE;
        end
        r_valid_d  = r_state_d == R_RESP;
        ar_ready_d = r_state_d == R_IDLE;
    end

    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_resp_d  = b_resp_q;
        if (commit) begin
            w_state_d = W_RESP;
            b_resp_d  = in_range(aw_addr_q) ? 2'b00 : 2'b10;
        end else if (w_state_q == W_COLLECT) begin
            if (aw_hs) begin
                aw_got_d  = 1'b1;
                aw_addr_d = bus.aw_addr;
            end
            if (w_hs) begin
                w_got_d  = 1'b1;
                w_data_d = bus.w_data;
                w_strb_d = bus.w_strb;
            end
        end else if (b_hs) begin
            w_state_d = W_COLLECT;
            aw_got_d  = 1'b0;
            w_got_d   = 1'b0;
        end
        aw_ready_d = w_state_d == W_COLLECT && !aw_got_d;
        w_ready_d  = w_state_d == W_COLLECT && !w_got_d;
        b_valid_d  = w_state_d == W_RESP;
    end

    // R and B errors may land together, so the saturating add takes up to 2 per cycle
    always_comb begin
        rd_count_d  = rd_count_q + 32'(r_hs);
        wr_count_d  = wr_count_q + 32'(b_hs);
        err_sum     = {1'b0, err_count_q} + 17'(r_hs && r_resp_q == 2'b10)
                    + 17'(b_hs && b_resp_q == 2'b10);
        err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q   <= R_IDLE;
            r_cnt_q     <= '0;
            r_data_q    <= '0;
            r_resp_q    <= 2'b00;
            r_valid_q   <= 1'b0;
            ar_ready_q  <= 1'b0;
            w_state_q   <= W_COLLECT;
            aw_got_q    <= 1'b0;
            w_got_q     <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            aw_ready_q  <= 1'b0;
            w_ready_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            b_resp_q    <= 2'b00;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            r_state_q   <= r_state_d;
            r_cnt_q     <= r_cnt_d;
            r_data_q    <= r_data_d;
            r_resp_q    <= r_resp_d;
            r_valid_q   <= r_valid_d;
            ar_ready_q  <= ar_ready_d;
            w_state_q   <= w_state_d;
            aw_got_q    <= aw_got_d;
            w_got_q     <= w_got_d;
            aw_addr_q   <= aw_addr_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            aw_ready_q  <= aw_ready_d;
            w_ready_q   <= w_ready_d;
            b_valid_q   <= b_valid_d;
            b_resp_q    <= b_resp_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            err_count_q <= err_count_d;
        end
    end

    // memory has no reset so contents survive rst_i; a reset edge still cancels the commit
    always_ff @(posedge clk_i) begin
        if (!rst_i && commit && in_range(aw_addr_q))
            for (int b = 0; b < NB; b++)
                if (w_strb_q[b]) mem[word_idx(aw_addr_q)][8*b +: 8] <= w_data_q[8*b +: 8];
    end

    assign bus.ar_ready = ar_ready_q;
    assign bus.r_data   = r_data_q;
    assign bus.r_resp   = r_resp_q;
    assign bus.r_valid  = r_valid_q;
    assign bus.aw_ready = aw_ready_q;
    assign bus.w_ready  = w_ready_q;
    assign bus.b_valid  = b_valid_q;
    assign bus.b_resp   = b_resp_q;
    assign rd_count_o   = rd_count_q;
    assign wr_count_o   = wr_count_q;
    assign err_count_o  = err_count_q;
endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// tb_axi_lite_mem_responder: directed bench for the AXI-Lite memory responder
// (default parameters: 64-bit data, base 0x8000_0000, 1024 words, read latency 2).
module tb_axi_lite_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rd_count, wr_count;
    logic [15:0] err_count;
    int          checks = 0, passes = 0, fails = 0;

    always #5 clk = ~clk;

    axi_lite_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

    axi_lite_mem_responder dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .rd_count_o (rd_count),
        .wr_count_o (wr_count),
        .err_count_o(err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        fails++;
        $error("FAIL %s: timed out waiting for handshake", tag);
    endtask

    task automatic wait_b(output logic [1:0] resp, output int lat);
        lat = 0;
        while (!bus.b_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!bus.b_valid) timeout("b_valid");
        resp = bus.b_resp;
        bus.b_ready = 1'b1;
        tick();
        bus.b_ready = 1'b0;
    endtask

    task automatic write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                         output logic [1:0] resp, output int lat);
        logic aw_h, w_h;
        bus.aw_addr  = a;
        bus.w_data   = d;
        bus.w_strb   = s;
        bus.aw_valid = 1'b1;
        bus.w_valid  = 1'b1;
        for (int i = 0; i < 20 && (bus.aw_valid || bus.w_valid); i++) begin
            aw_h = bus.aw_ready;
            w_h  = bus.w_ready;
            tick();
            if (aw_h) bus.aw_valid = 1'b0;
            if (w_h) bus.w_valid = 1'b0;
        end
        if (bus.aw_valid || bus.w_valid) timeout("aw_w");
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        wait_b(resp, lat);
    endtask

    task automatic read(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp,
                        output int lat);
        bus.ar_addr  = a;
        bus.ar_valid = 1'b1;
        for (int i = 0; i < 20 && !bus.ar_ready; i++) tick();
        if (!bus.ar_ready) timeout("ar");
        tick();
        bus.ar_valid = 1'b0;
        lat = 1;
        while (!bus.r_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!bus.r_valid) timeout("r_valid");
        d    = bus.r_data;
        resp = bus.r_resp;
        bus.r_ready = 1'b1;
        tick();
        bus.r_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] data;
        logic [1:0]  resp;
        int          lat;
        bus.aw_addr = '0; bus.aw_valid = 1'b0; bus.w_data = '0; bus.w_strb = '0;
        bus.w_valid = 1'b0; bus.b_ready = 1'b0; bus.ar_addr = '0; bus.ar_valid = 1'b0;
        bus.r_ready = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_readys", {bus.ar_ready, bus.aw_ready, bus.w_ready}, 3'b000);
        chk("rst_valids", {bus.r_valid, bus.b_valid}, 2'b00);
        chk("rst_resps", {bus.r_resp, bus.b_resp}, 4'b0000);
        chk("rst_r_data", bus.r_data, 64'h0);
        chk("rst_counts", {rd_count, wr_count, err_count}, 80'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_readys", {bus.ar_ready, bus.aw_ready, bus.w_ready}, 3'b111);

        // basic write then read
        write(32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, resp, lat);
        chk("basic_b_resp", resp, 2'b00);
        chk("basic_b_lat", lat, 1);
        read(32'h8000_0008, data, resp, lat);
        chk("basic_r_data", data, 64'h1122_3344_5566_7788);
        chk("basic_r_resp", resp, 2'b00);
        chk("basic_r_lat", lat, 2);
        chk("basic_rd_count", rd_count, 1);
        chk("basic_wr_count", wr_count, 1);

        // partial strobe
        write(32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, resp, lat);
        write(32'h8000_0010, 64'h0, 8'h0F, resp, lat);
        read(32'h8000_0010, data, resp, lat);
        chk("strb_r_data", data, 64'hFFFF_FFFF_0000_0000);

        // W three cycles before AW
        bus.w_data = 64'hA1A1_A1A1_A1A1_A1A1; bus.w_strb = 8'hFF; bus.w_valid = 1'b1;
        tick();
        bus.w_valid = 1'b0;
        chk("wfirst_readys", {bus.aw_ready, bus.w_ready}, 2'b10);
        tick();
        tick();
        bus.aw_addr = 32'h8000_0018; bus.aw_valid = 1'b1;
        tick();
        bus.aw_valid = 1'b0;
        wait_b(resp, lat);
        chk("wfirst_b_resp", resp, 2'b00);

        // AW before W
        bus.aw_addr = 32'h8000_0020; bus.aw_valid = 1'b1;
        tick();
        bus.aw_valid = 1'b0;
        chk("awfirst_readys", {bus.aw_ready, bus.w_ready}, 2'b01);
        tick();
        chk("awfirst_hold", {bus.aw_ready, bus.b_valid}, 2'b00);
        bus.w_data = 64'hB2B2_B2B2_B2B2_B2B2; bus.w_strb = 8'hFF; bus.w_valid = 1'b1;
        tick();
        bus.w_valid = 1'b0;
        wait_b(resp, lat);
        chk("awfirst_b_resp", resp, 2'b00);

        // AW and W together
        write(32'h8000_0028, 64'hC3C3_C3C3_C3C3_C3C3, 8'hFF, resp, lat);
        chk("both_b_resp", resp, 2'b00);
        read(32'h8000_0018, data, resp, lat);
        chk("wfirst_data", data, 64'hA1A1_A1A1_A1A1_A1A1);
        read(32'h8000_0020, data, resp, lat);
        chk("awfirst_data", data, 64'hB2B2_B2B2_B2B2_B2B2);
        read(32'h8000_0028, data, resp, lat);
        chk("both_data", data, 64'hC3C3_C3C3_C3C3_C3C3);
        chk("order_wr_count", wr_count, 6);
        chk("order_rd_count", rd_count, 5);

        // out of range: below base and one word past the end (index would alias word 0)
        write(32'h8000_0000, 64'h0BAD_F00D_1234_5678, 8'hFF, resp, lat);
        read(32'h7FFF_FFF8, data, resp, lat);
        chk("oor_r_resp", resp, 2'b10);
        chk("oor_r_data", data, 64'h0);
        write(32'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, resp, lat);
        chk("oor_b_resp", resp, 2'b10);
        chk("oor_err_count", err_count, 2);
        read(32'h8000_0000, data, resp, lat);
        chk("oor_mem_kept", data, 64'h0BAD_F00D_1234_5678);
        chk("oor_last_resp", resp, 2'b00);

        // B backpressure with a competing AW held
        bus.aw_addr = 32'h8000_0030; bus.w_data = 64'h5A5A_5A5A_5A5A_5A5A; bus.w_strb = 8'hFF;
        bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
        tick();
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.b_valid; i++) tick();
        bus.aw_addr = 32'h8000_0038; bus.aw_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_b_hold", {bus.b_valid, bus.b_resp, bus.aw_ready, bus.w_ready}, 5'b1_00_00);
            if (i < 4) tick();
        end
        bus.b_ready = 1'b1; bus.aw_valid = 1'b0;
        tick();
        bus.b_ready = 1'b0;
        chk("bp_wr_count", wr_count, 9);
        chk("bp_b_done", {bus.b_valid, bus.aw_ready}, 2'b01);

        // R backpressure with a competing AR held
        bus.ar_addr = 32'h8000_0030; bus.ar_valid = 1'b1;
        tick();
        bus.ar_addr = 32'h8000_0008;
        for (int i = 0; i < 20 && !bus.r_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_r_hold", {bus.r_valid, bus.r_resp, bus.ar_ready}, 4'b1_00_0);
            chk("bp_r_data", bus.r_data, 64'h5A5A_5A5A_5A5A_5A5A);
            tick();
        end
        bus.r_ready = 1'b1; bus.ar_valid = 1'b0;
        tick();
        bus.r_ready = 1'b0;
        chk("bp_rd_count", rd_count, 8);
        chk("bp_err_count", err_count, 2);

        // reset while a read waits and a write holds only its AW
        bus.ar_addr = 32'h8000_0008; bus.ar_valid = 1'b1;
        bus.aw_addr = 32'h8000_0008; bus.aw_valid = 1'b1;
        tick();
        bus.ar_valid = 1'b0; bus.aw_valid = 1'b0;
        chk("mr_in_flight", {bus.r_valid, bus.ar_ready, bus.aw_ready, bus.w_ready}, 4'b0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_valids", {bus.r_valid, bus.b_valid}, 2'b00);
        chk("mr_counts", {rd_count, wr_count, err_count}, 80'h0);
        chk("mr_r_data", bus.r_data, 64'h0);
        tick();
        chk("mr_readys", {bus.ar_ready, bus.aw_ready, bus.w_ready, bus.r_valid}, 4'b1110);
        bus.w_data = 64'hEEEE_EEEE_EEEE_EEEE; bus.w_strb = 8'hFF; bus.w_valid = 1'b1;
        tick();
        bus.w_valid = 1'b0;
        tick();
        tick();
        chk("mr_aw_dropped", {bus.b_valid, bus.aw_ready, bus.w_ready}, 3'b010);
        read(32'h8000_0008, data, resp, lat);
        chk("mr_mem_kept", data, 64'h1122_3344_5566_7788);
        chk("mr_rd_count", rd_count, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
